// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the PWM generator family.
//   PWM_DIV_50M     : clk cycles per 10 us tick at 50 MHz
//   PWM_PERIOD_20MS : ticks per 20 ms servo/motor frame
//   PWM_CW          : default counter / duty width
//   clog2_min1()    : $clog2 that never returns 0, for index port widths
package pwm_pkg;

  localparam int PWM_DIV_50M     = 500;
  localparam int PWM_PERIOD_20MS = 2000;
  localparam int PWM_CW          = 12;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Tick prescaler: divides clk by DIV.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   tick  : high for the single clk where the prescaler sits at DIV-1
module pwm_prescaler
  import pwm_pkg::*;
#(
  parameter int DIV = PWM_DIV_50M
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int PW = clog2_min1(DIV);
  localparam logic [PW-1:0] LAST_C = PW'(DIV - 1);

  logic [PW-1:0] pre_q;
  logic [PW-1:0] pre_d;

  assign tick  = (pre_q == LAST_C);
  assign pre_d = tick ? '0 : pre_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

endmodule

// File: rtl/pwm_multi_gen.sv
// Multi-channel PWM generator with a shared period counter.
//   clk, rst_n    : system clock, asynchronous active-low reset
//   en            : global enable, low forces pwm_out low on the next clk
//   half_speed    : compare against active duty >> 1
//   ramp_en       : active duty slews toward pending by at most RAMP_STEP per period
//   wr_en/wr_ch/wr_duty : duty write into a channel's pending register
//   pwm_out       : registered PWM outputs, one per channel
//   period_start  : one-clk pulse the clk after the counter wraps
//   busy          : some channel's active duty differs from its pending duty
module pwm_multi_gen
  import pwm_pkg::*;
#(
  parameter int NCH       = 4,
  parameter int CW        = PWM_CW,
  parameter int DIV       = PWM_DIV_50M,
  parameter int PERIOD    = PWM_PERIOD_20MS,
  parameter int RAMP_STEP = 16,
  localparam int CHW      = clog2_min1(NCH)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic           half_speed,
  input  logic           ramp_en,
  input  logic           wr_en,
  input  logic [CHW-1:0] wr_ch,
  input  logic [CW-1:0]  wr_duty,
  output logic [NCH-1:0] pwm_out,
  output logic           period_start,
  output logic           busy
);

  localparam logic [CW-1:0] PERIOD_C = CW'(PERIOD);
  localparam logic [CW-1:0] LAST_C   = CW'(PERIOD - 1);
  localparam logic [CW:0]   STEP_C   = (CW + 1)'(RAMP_STEP);

  logic          tick;
  logic          wrap;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [CW-1:0] next_cnt;
  logic [CW-1:0] wr_clamp;

  logic [NCH-1:0] pwm_q;
  logic [NCH-1:0] pwm_d;
  logic [NCH-1:0] diff_v;
  logic           period_start_q;
  logic           busy_q;

  pwm_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // wrap is the boundary event: shadow loads and period_start key off it
  assign wrap     = tick && (cnt_q == LAST_C);
  assign next_cnt = wrap ? '0 : cnt_q + 1'b1;
  assign cnt_d    = tick ? next_cnt : cnt_q;
  assign wr_clamp = (wr_duty > PERIOD_C) ? PERIOD_C : wr_duty;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic          wr_hit;
    logic [CW-1:0] pending_q;
    logic [CW-1:0] pending_d;
    logic [CW-1:0] active_q;
    logic [CW-1:0] active_d;
    logic [CW-1:0] stepped;
    logic [CW-1:0] cmp;
    logic [CW:0]   act_x;
    logic [CW:0]   pend_x;

    // Out-of-range indices never match any channel, so they are dropped.
    assign wr_hit    = wr_en && (wr_ch == CHW'(i));
    // pending_d doubles as the forwarding path for a write on the boundary clk
    assign pending_d = wr_hit ? wr_clamp : pending_q;

    assign act_x  = {1'b0, active_q};
    assign pend_x = {1'b0, pending_d};

    // Slew one step toward pending; a remaining gap within one step lands
    // exactly on pending, so there is no overshoot and no wrap.
    always_comb begin
      stepped = pending_d;
      if (pend_x > act_x) begin
        if ((pend_x - act_x) > STEP_C) stepped = CW'(act_x + STEP_C);
      end else if (act_x > pend_x) begin
        if ((act_x - pend_x) > STEP_C) stepped = CW'(act_x - STEP_C);
      end
    end

    assign active_d = wrap ? (ramp_en ? stepped : pending_d) : active_q;

    // Compare uses the freshly loaded duty so a boundary load governs the
    // very first tick of the new period.
    assign cmp      = half_speed ? (active_d >> 1) : active_d;
    assign pwm_d[i] = !en ? 1'b0 : (tick ? (next_cnt < cmp) : pwm_q[i]);
    assign diff_v[i] = (active_d != pending_d);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pending_q <= '0;
        active_q  <= '0;
      end else begin
        pending_q <= pending_d;
        active_q  <= active_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q          <= '0;
      pwm_q          <= '0;
      period_start_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      pwm_q          <= pwm_d;
      period_start_q <= wrap;
      busy_q         <= |diff_v;
    end
  end

  assign pwm_out      = pwm_q;
  assign period_start = period_start_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_pwm_multi_gen.sv
module tb_pwm_multi_gen;

  localparam int NCH       = 2;
  localparam int CW        = 12;
  localparam int DIV       = 4;
  localparam int PERIOD    = 10;
  localparam int RAMP_STEP = 3;

  logic           clk;
  logic           rst_n;
  logic           en;
  logic           half_speed;
  logic           ramp_en;
  logic           wr_en;
  logic [0:0]     wr_ch;
  logic [CW-1:0]  wr_duty;
  logic [NCH-1:0] pwm_out;
  logic           period_start;
  logic           busy;

  int checks = 0;
  int errors = 0;

  pwm_multi_gen #(
    .NCH       (NCH),
    .CW        (CW),
    .DIV       (DIV),
    .PERIOD    (PERIOD),
    .RAMP_STEP (RAMP_STEP)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .half_speed   (half_speed),
    .ramp_en      (ramp_en),
    .wr_en        (wr_en),
    .wr_ch        (wr_ch),
    .wr_duty      (wr_duty),
    .pwm_out      (pwm_out),
    .period_start (period_start),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [NCH-1:0] pwm;
    logic           ps;
    logic           bsy;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: time is counted in clks since reset release; the tick
  // index and period phase follow from plain division.
  int unsigned ncyc;
  int          pend_m[NCH];
  int          act_m[NCH];
  logic [NCH-1:0] pwm_m;

  always @(posedge clk or negedge rst_n) begin
    exp_t e;
    int   ntick, nxt, cmp, gap;
    bit   tk, wr;
    if (!rst_n) begin
      ncyc  = 0;
      pwm_m = '0;
      for (int i = 0; i < NCH; i++) begin
        pend_m[i] = 0;
        act_m[i]  = 0;
      end
      exp_q.delete();
      e = '0;
      exp_q.push_back(e);
    end else begin
      tk    = ((ncyc % DIV) == DIV - 1);
      ntick = ncyc / DIV;
      nxt   = (ntick + 1) % PERIOD;
      wr    = tk && (nxt == 0);
      if (wr_en && int'(wr_ch) < NCH)
        pend_m[int'(wr_ch)] = (int'(wr_duty) > PERIOD) ? PERIOD : int'(wr_duty);
      if (wr) begin
        for (int i = 0; i < NCH; i++) begin
          gap = pend_m[i] - act_m[i];
          if (!ramp_en)             act_m[i] = pend_m[i];
          else if (gap > RAMP_STEP)  act_m[i] = act_m[i] + RAMP_STEP;
          else if (gap < -RAMP_STEP) act_m[i] = act_m[i] - RAMP_STEP;
          else                       act_m[i] = pend_m[i];
        end
      end
      if (!en) pwm_m = '0;
      else if (tk) begin
        for (int i = 0; i < NCH; i++) begin
          cmp = half_speed ? act_m[i] / 2 : act_m[i];
          pwm_m[i] = (nxt < cmp);
        end
      end
      e.pwm = pwm_m;
      e.ps  = wr;
      e.bsy = 1'b0;
      for (int i = 0; i < NCH; i++) if (act_m[i] != pend_m[i]) e.bsy = 1'b1;
      exp_q.push_back(e);
      ncyc++;
    end
  end

  // Scoreboard monitor: one expected entry per clk, compared mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({pwm_out, period_start, busy} !== e) begin
        errors++;
        $display("FAIL scoreboard t=%0t pwm_out=%b exp=%b period_start=%b exp=%b busy=%b exp=%b",
                 $time, pwm_out, e.pwm, period_start, e.ps, busy, e.bsy);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic write(input int ch, input int duty);
    wr_en   = 1'b1;
    wr_ch   = ch[0:0];
    wr_duty = duty[CW-1:0];
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic wait_ps(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (period_start !== 1'b1 && n < 100);
    chk({name, "_period_start_seen"}, int'(period_start === 1'b1), 1);
  endtask

  task automatic count_win(output int h0, output int h1, output int ps);
    h0 = 0; h1 = 0; ps = 0;
    for (int k = 0; k < DIV * PERIOD; k++) begin
      @(negedge clk);
      if (pwm_out[0] === 1'b1) h0++;
      if (pwm_out[1] === 1'b1) h1++;
      if (period_start === 1'b1) ps++;
    end
  endtask

  initial begin
    int h0, h1, ps;
    rst_n = 1'b0; en = 1'b0; half_speed = 1'b0; ramp_en = 1'b0;
    wr_en = 1'b0; wr_ch = '0; wr_duty = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;

    // basic duties: 4 of 10 and full-on
    write(0, 4);
    write(1, 10);
    wait_ps("first_boundary");
    count_win(h0, h1, ps);
    chk("ch0_high_clks_duty4", h0, 16);
    chk("ch1_high_clks_full", h1, 40);
    chk("period_start_per_period", ps, 1);

    // mid-period write waits for the boundary
    repeat (5) @(negedge clk);
    write(0, 7);
    wait_ps("after_mid_write");
    count_win(h0, h1, ps);
    chk("ch0_high_clks_duty7", h0, 28);

    // write landing on the boundary clk applies to the new period at once
    repeat (DIV * PERIOD - 1) @(negedge clk);
    write(1, 3);
    count_win(h0, h1, ps);
    chk("ch1_boundary_write_duty3", h1, 12);

    // ramp 0 -> 10 in steps of 3
    write(0, 0);
    wait_ps("ramp_prep");
    ramp_en = 1'b1;
    repeat (3) @(negedge clk);
    write(0, 10);
    chk("busy_after_ramp_write", int'(busy), 1);
    wait_ps("ramp_b1"); chk("busy_ramp_3", int'(busy), 1);
    wait_ps("ramp_b2"); chk("busy_ramp_6", int'(busy), 1);
    wait_ps("ramp_b3"); chk("busy_ramp_9", int'(busy), 1);
    wait_ps("ramp_b4"); chk("busy_ramp_10", int'(busy), 0);
    ramp_en = 1'b0;

    // half speed with active 7
    write(0, 7);
    wait_ps("half_prep");
    repeat (6) @(negedge clk);
    half_speed = 1'b1;
    wait_ps("half_on");
    count_win(h0, h1, ps);
    chk("ch0_half_speed_clks", h0, 12);
    repeat (6) @(negedge clk);
    half_speed = 1'b0;
    wait_ps("half_off");
    count_win(h0, h1, ps);
    chk("ch0_full_speed_clks", h0, 28);

    // en low while ch1 is high
    wait_ps("en_prep");
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    chk("pwm_cleared_after_en_low", int'(pwm_out), 0);
    wait_ps("period_start_with_en_low");
    repeat (3) @(negedge clk);
    en = 1'b1;
    repeat (DIV * 3) @(negedge clk);

    // async reset mid-period, ch1 high at that moment
    wait_ps("rst_prep");
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("pwm_async_clear", int'(pwm_out), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_ps("after_reset");
    count_win(h0, h1, ps);
    chk("outputs_low_after_reset", h0 + h1, 0);

    // randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      wr_en   = ($urandom_range(0, 7) == 0);
      wr_ch   = 1'($urandom_range(0, 1));
      wr_duty = CW'($urandom_range(0, 13));
      if ($urandom_range(0, 199) == 0) en = ~en;
      if ($urandom_range(0, 149) == 0) half_speed = ~half_speed;
      if ($urandom_range(0, 99) == 0) ramp_en = ~ramp_en;
    end
    wr_en = 1'b0;
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
